// File: rtl/exc_ctrl.sv
// Commit-stage exception/ERET controller: CP0 update, pipeline flush, fetch redirect.
// Optional interrupt acceptance is enabled by defining EXC_CTRL_IRQ_EN.
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        commit_valid,
    input  logic [31:0] commit_pc,
    input  logic [31:0] commit_addr,
    input  logic        commit_bd,
    input  logic [6:0]  commit_exc,
    input  logic        commit_eret,
    input  logic [7:0]  interrupt_info,
    input  logic [31:0] cp0_epc,
    output logic        cp0_exc_en,
    output logic [4:0]  cp0_ecode,
    output logic [31:0] cp0_exc_pc,
    output logic [31:0] cp0_exc_addr,
    output logic        cp0_bd,
    output logic        cp0_eret_en,
    output logic        flush,
    output logic        stall,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready
);

`ifdef EXC_CTRL_IRQ_EN
    localparam logic IRQ_EN = 1'b1;
`else
    localparam logic IRQ_EN = 1'b0;
`endif

    localparam logic [3:0] FLUSH_N = 4'(FLUSH_CYCLES);

    typedef enum logic [1:0] {IDLE, COMMIT, FLUSH, REDIRECT} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        is_eret;

    logic        irq;
    logic        ev_exc;
    logic        ev_any;
    logic [4:0]  ev_ecode;
    logic [31:0] ev_addr;

    assign irq = IRQ_EN & commit_valid & (|interrupt_info);

    always_comb begin
        ev_exc   = 1'b1;
        ev_ecode = 5'd0;
        ev_addr  = 32'd0;
        if (irq) begin
            ev_ecode = 5'd0;
        end else if (commit_exc[0]) begin
            ev_ecode = 5'd4;
            ev_addr  = commit_pc;
        end else if (commit_exc[1]) begin
            ev_ecode = 5'd10;
        end else if (commit_exc[4]) begin
            ev_ecode = 5'd12;
        end else if (commit_exc[2]) begin
            ev_ecode = 5'd8;
        end else if (commit_exc[3]) begin
            ev_ecode = 5'd9;
        end else if (commit_exc[5]) begin
            ev_ecode = 5'd4;
            ev_addr  = commit_addr;
        end else if (commit_exc[6]) begin
            ev_ecode = 5'd5;
            ev_addr  = commit_addr;
        end else begin
            ev_exc   = 1'b0;
        end
    end

    assign ev_any = commit_valid & (ev_exc | commit_eret);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            is_eret        <= 1'b0;
            cp0_exc_en     <= 1'b0;
            cp0_ecode      <= 5'd0;
            cp0_exc_pc     <= 32'd0;
            cp0_exc_addr   <= 32'd0;
            cp0_bd         <= 1'b0;
            cp0_eret_en    <= 1'b0;
            flush          <= 1'b0;
            stall          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ev_any) begin
                        state        <= COMMIT;
                        stall        <= 1'b1;
                        flush        <= 1'b1;
                        is_eret      <= ~ev_exc;
                        cp0_exc_en   <= ev_exc;
                        cp0_eret_en  <= ~ev_exc;
                        cp0_ecode    <= ev_ecode;
                        cp0_exc_pc   <= commit_pc;
                        cp0_exc_addr <= ev_addr;
                        cp0_bd       <= commit_bd;
                    end
                end
                COMMIT: begin
                    state       <= FLUSH;
                    cp0_exc_en  <= 1'b0;
                    cp0_eret_en <= 1'b0;
                    cnt         <= FLUSH_N;
                end
                FLUSH: begin
                    if (cnt == 4'd1) begin
                        state          <= REDIRECT;
                        cnt            <= 4'd0;
                        flush          <= 1'b0;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= is_eret ? cp0_epc : EXC_VECTOR;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                REDIRECT: begin
                    // Handshake completes on this edge; return to IDLE.
                    if (redirect_ready) begin
                        state          <= IDLE;
                        redirect_valid <= 1'b0;
                        stall          <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed self-checking bench for exc_ctrl.
// Vectors cover priority, latency, ERET, backpressure and mid-flight reset.
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic [31:0] commit_addr;
    logic        commit_bd;
    logic [6:0]  commit_exc;
    logic        commit_eret;
    logic [7:0]  interrupt_info;
    logic [31:0] cp0_epc;
    logic        cp0_exc_en;
    logic [4:0]  cp0_ecode;
    logic [31:0] cp0_exc_pc;
    logic [31:0] cp0_exc_addr;
    logic        cp0_bd;
    logic        cp0_eret_en;
    logic        flush;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exc_ctrl dut (
        .clk           (clk),
        .resetn        (resetn),
        .commit_valid  (commit_valid),
        .commit_pc     (commit_pc),
        .commit_addr   (commit_addr),
        .commit_bd     (commit_bd),
        .commit_exc    (commit_exc),
        .commit_eret   (commit_eret),
        .interrupt_info(interrupt_info),
        .cp0_epc       (cp0_epc),
        .cp0_exc_en    (cp0_exc_en),
        .cp0_ecode     (cp0_ecode),
        .cp0_exc_pc    (cp0_exc_pc),
        .cp0_exc_addr  (cp0_exc_addr),
        .cp0_bd        (cp0_bd),
        .cp0_eret_en   (cp0_eret_en),
        .flush         (flush),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .redirect_ready(redirect_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        commit_valid   = 1'b0;
        commit_pc      = 32'd0;
        commit_addr    = 32'd0;
        commit_bd      = 1'b0;
        commit_exc     = 7'd0;
        commit_eret    = 1'b0;
        interrupt_info = 8'd0;
    endtask

    // Present one instruction for a single sampling edge.
    task automatic fire(input logic [31:0] pc, input logic [31:0] addr,
                        input logic bd, input logic [6:0] exc,
                        input logic eret, input logic [7:0] irq);
        commit_valid   = 1'b1;
        commit_pc      = pc;
        commit_addr    = addr;
        commit_bd      = bd;
        commit_exc     = exc;
        commit_eret    = eret;
        interrupt_info = irq;
        step();
        idle_inputs();
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (stall && n < 20) begin
            step();
            n++;
        end
        chk(tag, {31'd0, stall}, 32'd0);
    endtask

    initial begin
        logic [4:0] exp_irq_code;
`ifdef EXC_CTRL_IRQ_EN
        exp_irq_code = 5'd0;
`else
        exp_irq_code = 5'd8;
`endif
        idle_inputs();
        cp0_epc        = 32'h8000_0100;
        redirect_ready = 1'b1;
        resetn         = 1'b0;
        #12;
        chk("rst_stall", {31'd0, stall}, 0);
        chk("rst_flush", {31'd0, flush}, 0);
        chk("rst_rv", {31'd0, redirect_valid}, 0);
        chk("rst_rpc", redirect_pc, 0);
        chk("rst_ecode", {27'd0, cp0_ecode}, 0);
        @(negedge clk);
        resetn = 1'b1;

        // No acceptance without commit_valid.
        commit_exc     = 7'b0010000;
        interrupt_info = 8'hFF;
        step();
        chk("novalid_stall", {31'd0, stall}, 0);
        idle_inputs();

        // Overflow in delay slot: full latency trace.
        fire(32'h8000_0010, 32'h0, 1'b1, 7'b0010000, 1'b0, 8'h0);
        chk("ov_exc_en", {31'd0, cp0_exc_en}, 1);
        chk("ov_eret_en", {31'd0, cp0_eret_en}, 0);
        chk("ov_ecode", {27'd0, cp0_ecode}, 12);
        chk("ov_pc", cp0_exc_pc, 32'h8000_0010);
        chk("ov_addr", cp0_exc_addr, 0);
        chk("ov_bd", {31'd0, cp0_bd}, 1);
        chk("ov_flush1", {31'd0, flush}, 1);
        chk("ov_stall", {31'd0, stall}, 1);
        step();
        chk("ov_pulse_end", {31'd0, cp0_exc_en}, 0);
        chk("ov_flush2", {31'd0, flush}, 1);
        chk("ov_ecode_hold", {27'd0, cp0_ecode}, 12);
        step();
        chk("ov_flush3", {31'd0, flush}, 1);
        chk("ov_rv_early", {31'd0, redirect_valid}, 0);
        step();
        chk("ov_flush_off", {31'd0, flush}, 0);
        chk("ov_rv", {31'd0, redirect_valid}, 1);
        chk("ov_rpc", redirect_pc, 32'hBFC0_0380);
        chk("ov_bd_hold", {31'd0, cp0_bd}, 1);
        step();
        chk("ov_idle_rv", {31'd0, redirect_valid}, 0);
        chk("ov_idle_stall", {31'd0, stall}, 0);

        // Fetch AdEL beats data AdEL.
        fire(32'h8000_0004, 32'h1003, 1'b0, 7'b0100001, 1'b0, 8'h0);
        chk("ifadel_ecode", {27'd0, cp0_ecode}, 4);
        chk("ifadel_addr", cp0_exc_addr, 32'h8000_0004);
        wait_idle("ifadel_done");

        // ERET.
        fire(32'h8000_0020, 32'h0, 1'b0, 7'd0, 1'b1, 8'h0);
        chk("eret_en", {31'd0, cp0_eret_en}, 1);
        chk("eret_noexc", {31'd0, cp0_exc_en}, 0);
        step();
        chk("eret_pulse_end", {31'd0, cp0_eret_en}, 0);
        step();
        step();
        chk("eret_rv", {31'd0, redirect_valid}, 1);
        chk("eret_rpc", redirect_pc, 32'h8000_0100);
        wait_idle("eret_done");

        // Interrupt vs syscall, build-dependent.
        fire(32'h8000_0030, 32'h0, 1'b0, 7'b0000100, 1'b0, 8'h80);
        chk("irq_ecode", {27'd0, cp0_ecode}, {27'd0, exp_irq_code});
        chk("irq_exc_en", {31'd0, cp0_exc_en}, 1);
        wait_idle("irq_done");

        // Data AdES address capture.
        fire(32'h8000_0040, 32'h0000_2222, 1'b0, 7'b1000000, 1'b0, 8'h0);
        chk("ades_ecode", {27'd0, cp0_ecode}, 5);
        chk("ades_addr", cp0_exc_addr, 32'h0000_2222);
        wait_idle("ades_done");

        // Breakpoint plus ERET: exception wins.
        fire(32'h8000_0050, 32'h0, 1'b0, 7'b0001000, 1'b1, 8'h0);
        chk("bperet_ecode", {27'd0, cp0_ecode}, 9);
        chk("bperet_exc", {31'd0, cp0_exc_en}, 1);
        chk("bperet_eret", {31'd0, cp0_eret_en}, 0);
        step();
        step();
        step();
        chk("bperet_rpc", redirect_pc, 32'hBFC0_0380);
        wait_idle("bperet_done");

        // RI with fetch backpressure.
        redirect_ready = 1'b0;
        fire(32'h8000_0060, 32'h0, 1'b0, 7'b0000010, 1'b0, 8'h0);
        chk("ri_ecode", {27'd0, cp0_ecode}, 10);
        step();
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_rv", {31'd0, redirect_valid}, 1);
            chk("bp_rpc", redirect_pc, 32'hBFC0_0380);
            chk("bp_stall", {31'd0, stall}, 1);
            step();
        end
        redirect_ready = 1'b1;
        step();
        chk("bp_rel_stall", {31'd0, stall}, 0);
        chk("bp_rel_rv", {31'd0, redirect_valid}, 0);

        // Reset asserted during FLUSH.
        fire(32'h8000_0070, 32'h0, 1'b1, 7'b0010000, 1'b0, 8'h0);
        step();
        resetn = 1'b0;
        #1;
        chk("mrst_flush", {31'd0, flush}, 0);
        chk("mrst_stall", {31'd0, stall}, 0);
        chk("mrst_ecode", {27'd0, cp0_ecode}, 0);
        chk("mrst_pc", cp0_exc_pc, 0);
        chk("mrst_bd", {31'd0, cp0_bd}, 0);
        @(negedge clk);
        resetn = 1'b1;
        fire(32'h8000_0080, 32'h0, 1'b0, 7'b0000100, 1'b0, 8'h0);
        chk("post_ecode", {27'd0, cp0_ecode}, 8);
        chk("post_exc_en", {31'd0, cp0_exc_en}, 1);
        chk("post_pc", cp0_exc_pc, 32'h8000_0080);
        step();
        step();
        step();
        chk("post_rv", {31'd0, redirect_valid}, 1);
        wait_idle("post_done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
